// File: rtl/key_latch_driver.sv
// Upstream driver for a bank of active-low NAND set/reset hit latches: synchronises and
// debounces raw keys, turns each press into a one-cycle notS pulse, and issues timed clears.
module key_latch_driver #(
    parameter int N_KEYS    = 4,
    parameter int DB_CYCLES = 16,
    parameter int CLR_HOLD  = 2
) (
    input  logic              clk,
    input  logic              notRst,
    input  logic [N_KEYS-1:0] key_in,
    input  logic              clr_req,
    output logic [N_KEYS-1:0] notS,
    output logic [N_KEYS-1:0] notR,
    output logic [N_KEYS-1:0] key_state,
    output logic              busy,
    output logic [1:0]        fsm_state_o
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam int HW = (CLR_HOLD > 1) ? $clog2(CLR_HOLD) : 1;
    localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(CLR_HOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    logic [N_KEYS-1:0] sync1_q, sync2_q;
    logic [CW-1:0]     db_cnt_q [N_KEYS];
    logic [CW-1:0]     db_cnt_d [N_KEYS];
    logic [N_KEYS-1:0] ks_q, ks_d;
    logic [N_KEYS-1:0] rise;

    state_t            state_q, state_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [N_KEYS-1:0] pend_q, pend_d;
    logic [N_KEYS-1:0] nots_q, nots_d;
    logic              notr_q, notr_d;
    logic              busy_q, busy_d;

    // Debounce: the stable level flips only after DB_CYCLES consecutive disagreeing samples.
    always_comb begin
        ks_d = ks_q;
        rise = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != ks_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    ks_d[i] = ~ks_q[i];
                    rise[i] = ~ks_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        pend_d  = pend_q | rise;
        nots_d  = '1;
        notr_d  = notr_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    hold_d  = '0;
                    notr_d  = 1'b0;
                end else begin
                    // notR is high here, so issuing set pulses cannot hit the forbidden input.
                    notr_d = 1'b1;
                    nots_d = ~(pend_q | rise);
                    pend_d = '0;
                end
            end
            ST_CLEAR: begin
                notr_d = 1'b0;
                if (clr_req) begin
                    hold_d = '0;
                end else if (hold_q == HOLD_LAST) begin
                    notr_d  = 1'b1;
                    hold_d  = '0;
                    state_d = ST_GUARD;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            ST_GUARD: begin
                notr_d = 1'b1;
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    hold_d  = '0;
                    notr_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                hold_d  = '0;
                notr_d  = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge notRst) begin
        if (!notRst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            ks_q    <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                db_cnt_q[i] <= '0;
            end
            state_q <= ST_CLEAR;
            hold_q  <= '0;
            pend_q  <= '0;
            nots_q  <= '1;
            notr_q  <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
            ks_q    <= ks_d;
            for (int i = 0; i < N_KEYS; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            state_q <= state_d;
            hold_q  <= hold_d;
            pend_q  <= pend_d;
            nots_q  <= nots_d;
            notr_q  <= notr_d;
            busy_q  <= busy_d;
        end
    end

    assign notS        = nots_q;
    assign notR        = {N_KEYS{notr_q}};
    assign key_state   = ks_q;
    assign busy        = busy_q;
    assign fsm_state_o = state_q;

endmodule

// File: tb/tb_key_latch_driver.sv
// Bench for key_latch_driver with DB_CYCLES=4, CLR_HOLD=2: per-cycle expected outputs
// {notS, notR, key_state, busy} are queued as stimulus is applied and compared each negedge.
module tb_key_latch_driver;

    localparam logic [3:0] F = 4'hF;

    logic       clk;
    logic       notRst;
    logic [3:0] key_in;
    logic       clr_req;
    logic [3:0] notS;
    logic [3:0] notR;
    logic [3:0] key_state;
    logic       busy;
    logic [1:0] fsm_state;

    key_latch_driver #(
        .N_KEYS    (4),
        .DB_CYCLES (4),
        .CLR_HOLD  (2)
    ) dut (
        .clk         (clk),
        .notRst      (notRst),
        .key_in      (key_in),
        .clr_req     (clr_req),
        .notS        (notS),
        .notR        (notR),
        .key_state   (key_state),
        .busy        (busy),
        .fsm_state_o (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          step_no = 0;
    string       tag = "init";
    logic [12:0] exp_q[$];
    logic [12:0] mon_exp;
    logic [12:0] mon_got;

    typedef struct {
        logic [3:0] mask;
        int         hi;
        bit         pulse;
    } vec_t;
    vec_t tbl[6];

    function automatic logic [12:0] mk(logic [3:0] ns, logic [3:0] nr, logic [3:0] ks, logic b);
        return {ns, nr, ks, b};
    endfunction

    task automatic chk(input string name, input logic [12:0] got, input logic [12:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got notS=%b notR=%b ks=%b busy=%b, want notS=%b notR=%b ks=%b busy=%b",
                     name, got[12:9], got[8:5], got[4:1], got[0], exp[12:9], exp[8:5], exp[4:1], exp[0]);
        end
    endtask

    // scoreboard: one expected record per clock edge, compared on the following negedge
    always @(negedge clk) begin
        if (notRst) begin
            checks++;
            if ((~notS & ~notR) != 4'b0000) begin
                errors++;
                $display("FAIL invariant: notS=%b notR=%b both low at %0t", notS, notR, $time);
            end
        end
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_got = {notS, notR, key_state, busy};
            step_no++;
            checks++;
            if (mon_got !== mon_exp) begin
                errors++;
                $display("FAIL %s step %0d (fsm=%0d): got notS=%b notR=%b ks=%b busy=%b, want notS=%b notR=%b ks=%b busy=%b",
                         tag, step_no, fsm_state, mon_got[12:9], mon_got[8:5], mon_got[4:1], mon_got[0],
                         mon_exp[12:9], mon_exp[8:5], mon_exp[4:1], mon_exp[0]);
            end
        end
    end

    // driver: inputs applied just after an edge, sampled by the DUT at the next edge
    task automatic step(input logic [3:0] key, input logic clr, input logic [12:0] exp);
        key_in  = key;
        clr_req = clr;
        @(posedge clk);
        exp_q.push_back(exp);
        #1;
    endtask

    task automatic start(input string name);
        tag     = name;
        step_no = 0;
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        #1;
        notRst  = 1'b0;
        key_in  = 4'b0000;
        clr_req = 1'b0;
        #1;
        chk({name, "_async"}, {notS, notR, key_state, busy}, mk(F, 4'h0, 4'h0, 1'b1));
        @(posedge clk);
        @(posedge clk);
        #1;
        chk({name, "_held"}, {notS, notR, key_state, busy}, mk(F, 4'h0, 4'h0, 1'b1));
        notRst = 1'b1;
    endtask

    task automatic post_reset(input string name);
        start(name);
        step(4'h0, 1'b0, mk(F, 4'h0, 4'h0, 1'b1));
        step(4'h0, 1'b0, mk(F, F, 4'h0, 1'b1));
        step(4'h0, 1'b0, mk(F, F, 4'h0, 1'b0));
        repeat (6) step(4'h0, 1'b0, mk(F, F, 4'h0, 1'b0));
    endtask

    initial begin
        logic [3:0] key, ks_e, ns_e, nr_e;
        logic       clr, b_e;

        tbl[0] = '{mask: 4'b0001, hi: 8, pulse: 1'b1};
        tbl[1] = '{mask: 4'b0010, hi: 3, pulse: 1'b0};
        tbl[2] = '{mask: 4'b0010, hi: 4, pulse: 1'b1};
        tbl[3] = '{mask: 4'b0100, hi: 2, pulse: 1'b0};
        tbl[4] = '{mask: 4'b1100, hi: 6, pulse: 1'b1};
        tbl[5] = '{mask: 4'b1000, hi: 1, pulse: 1'b0};

        notRst  = 1'b0;
        key_in  = 4'b0000;
        clr_req = 1'b0;

        do_reset("power_on_reset");
        post_reset("post_reset_clear");

        // press/glitch table: key high for hi cycles from the first call
        for (int r = 0; r < 6; r++) begin
            start($sformatf("vec%0d", r));
            for (int j = 1; j <= tbl[r].hi + 12; j++) begin
                key  = (j <= tbl[r].hi) ? tbl[r].mask : 4'h0;
                ks_e = (tbl[r].pulse && j >= 6 && j <= tbl[r].hi + 5) ? tbl[r].mask : 4'h0;
                ns_e = (tbl[r].pulse && j == 6) ? ~tbl[r].mask : F;
                step(key, 1'b0, mk(ns_e, F, ks_e, 1'b0));
            end
        end

        // clear coincides with the key_state rise: press is deferred past GUARD
        start("clr_vs_press");
        for (int j = 1; j <= 20; j++) begin
            key  = (j <= 10) ? 4'b0100 : 4'h0;
            clr  = (j == 6);
            ks_e = (j >= 6 && j <= 15) ? 4'b0100 : 4'h0;
            nr_e = (j == 6 || j == 7) ? 4'h0 : F;
            b_e  = (j >= 6 && j <= 8);
            ns_e = (j == 10) ? 4'b1011 : F;
            step(key, clr, mk(ns_e, nr_e, ks_e, b_e));
        end

        // repeated requests in CLEAR and GUARD
        start("clr_repeat");
        for (int j = 1; j <= 11; j++) begin
            clr  = (j == 1 || j == 3 || j == 6);
            nr_e = (j == 5 || j >= 8) ? F : 4'h0;
            b_e  = (j <= 8);
            step(4'h0, clr, mk(F, nr_e, 4'h0, b_e));
        end

        // two presses of key 0 during a long clear merge into one pulse
        start("merge");
        for (int j = 1; j <= 38; j++) begin
            key  = ((j <= 6) || (j >= 15 && j <= 22)) ? 4'b0001 : 4'h0;
            clr  = (j <= 30);
            ks_e = ((j >= 6 && j <= 11) || (j >= 20 && j <= 27)) ? 4'b0001 : 4'h0;
            nr_e = (j <= 31) ? 4'h0 : F;
            b_e  = (j <= 32);
            ns_e = (j == 34) ? 4'b1110 : F;
            step(key, clr, mk(ns_e, nr_e, ks_e, b_e));
        end

        // reset mid-clear with a press pending: the press must be discarded
        start("rst_mid_clear");
        for (int j = 1; j <= 8; j++) begin
            key  = (j <= 6) ? 4'b0001 : 4'h0;
            ks_e = (j >= 6) ? 4'b0001 : 4'h0;
            step(key, 1'b1, mk(F, 4'h0, ks_e, 1'b1));
        end
        do_reset("rst_mid_clear");
        post_reset("after_rst_mid_clear");

        // reset right after a set pulse is issued
        start("rst_mid_pulse");
        for (int j = 1; j <= 6; j++) begin
            ks_e = (j == 6) ? 4'b0001 : 4'h0;
            ns_e = (j == 6) ? 4'b1110 : F;
            step(4'b0001, 1'b0, mk(ns_e, F, ks_e, 1'b0));
        end
        do_reset("rst_mid_pulse");
        post_reset("after_rst_mid_pulse");

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected records left, want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
